// File: rtl/baud_tick_gen.sv
// -----------------------------------------------------------------------------
// baud_tick_gen
// Programmable baud-rate tick generator with a small register interface.
// A divide counter produces an oversample tick (os_tick) every `divisor` clks.
// A second counter then divides that by OSR to produce bit_tick.
//
// Ports
//   clk       in   1  clock, all state on the rising edge
//   rst       in   1  asynchronous active-high reset
//   iocs      in   1  chip select; an access happens only while high
//   iorw      in   1  1 = read, 0 = write
//   ioaddr    in   2  00 status, 01 control, 10 divisor low, 11 divisor high
//   data_in   in   8  write data
//   data_out  out  8  combinational read data (0 when not reading)
//   os_tick   out  1  registered oversample tick, one-clk pulse
//   bit_tick  out  1  registered bit tick, coincides with every OSR-th os_tick
//   running   out  1  enable=1 and active divisor != 0
//
// Register map
//   00 R   {6'b0, running, enable}      (writes ignored)
//   01 RW  bit0 enable, bit1 restart (write-only, self-clearing)
//   10 RW  write: staging low byte;  read: active divisor[7:0]
//   11 RW  write: commit {data_in, staging}; read: active divisor[15:8]
// -----------------------------------------------------------------------------
module baud_tick_gen #(
  parameter int DIV_W     = 16,
  parameter int OSR       = 16,
  parameter int RESET_DIV = 325,
  parameter int RESET_EN  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       os_tick,
  output logic       bit_tick,
  output logic       running
);

  localparam int OS_W = $clog2(OSR);
  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(RESET_DIV);
  localparam logic [DIV_W-1:0] RST_CNT = (RST_DIV == '0) ? '0 : RST_DIV - 1'b1;
  localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OSR - 1);
  localparam logic             RST_EN  = (RESET_EN != 0);

  logic [DIV_W-1:0] r_div;
  logic [7:0]       r_stage_lo;
  logic             r_en;
  logic [DIV_W-1:0] r_div_cnt;
  logic [OS_W-1:0]  r_os_cnt;
  logic             r_os_tick;
  logic             r_bit_tick;

  logic             w_wr;
  logic             w_wr_ctrl;
  logic             w_wr_lo;
  logic             w_wr_hi;
  logic             w_restart;
  logic             w_en_eff;
  logic             w_run;
  logic [DIV_W-1:0] w_new_div;
  logic [DIV_W-1:0] w_new_cnt;
  logic [DIV_W-1:0] w_reload;
  logic [15:0]      w_div16;

  assign w_wr      = iocs & ~iorw;
  assign w_wr_ctrl = w_wr & (ioaddr == 2'b01);
  assign w_wr_lo   = w_wr & (ioaddr == 2'b10);
  assign w_wr_hi   = w_wr & (ioaddr == 2'b11);
  assign w_restart = w_wr_ctrl & data_in[1];

  // Bits of the 16-bit value above DIV_W are simply dropped.
  assign w_new_div = DIV_W'({data_in, r_stage_lo});
  assign w_new_cnt = (w_new_div == '0) ? '0 : w_new_div - 1'b1;
  assign w_reload  = (r_div == '0) ? '0 : r_div - 1'b1;

  // A control write changes the enable seen by the counters on that same edge,
  // so a disable freezes the counters and keeps ticks low from the next cycle.
  assign w_en_eff  = w_wr_ctrl ? data_in[0] : r_en;
  assign w_run     = w_en_eff & (r_div != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div      <= RST_DIV;
      r_stage_lo <= 8'h00;
      r_en       <= RST_EN;
      r_div_cnt  <= RST_CNT;
      r_os_cnt   <= '0;
      r_os_tick  <= 1'b0;
      r_bit_tick <= 1'b0;
    end else begin
      r_os_tick  <= 1'b0;
      r_bit_tick <= 1'b0;
      if (w_wr_lo) begin
        r_stage_lo <= data_in;
      end
      if (w_wr_ctrl) begin
        r_en <= data_in[0];
      end
      // Commit and restart both realign the phase and suppress the tick of
      // their own cycle; they cannot coincide since there is one access port.
      if (w_wr_hi) begin
        r_div     <= w_new_div;
        r_div_cnt <= w_new_cnt;
        r_os_cnt  <= '0;
      end else if (w_restart) begin
        r_div_cnt <= w_reload;
        r_os_cnt  <= '0;
      end else if (w_run) begin
        if (r_div_cnt == '0) begin
          r_div_cnt <= w_reload;
          r_os_tick <= 1'b1;
          if (r_os_cnt == OS_LAST) begin
            r_os_cnt   <= '0;
            r_bit_tick <= 1'b1;
          end else begin
            r_os_cnt <= r_os_cnt + 1'b1;
          end
        end else begin
          r_div_cnt <= r_div_cnt - 1'b1;
        end
      end
    end
  end

  assign os_tick  = r_os_tick;
  assign bit_tick = r_bit_tick;
  assign running  = r_en & (r_div != '0);
  assign w_div16  = 16'(r_div);

  always_comb begin
    data_out = 8'h00;
    if (iocs && iorw) begin
      case (ioaddr)
        2'b00:   data_out = {6'b0, running, r_en};
        2'b01:   data_out = {7'b0, r_en};
        2'b10:   data_out = w_div16[7:0];
        default: data_out = w_div16[15:8];
      endcase
    end
  end

endmodule

// File: doc/baud_tick_gen.md
BAUD_TICK_GEN -- requirements
Module: baud_tick_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 16, meaning divisor width (legal 2..16); divisor byte bits beyond DIV_W are ignored on write and read back as 0.
REQ-002 SHALL have parameter OSR, default 16, meaning oversample ticks per bit tick (legal 2..64).
REQ-003 SHALL have parameter RESET_DIV, default 325, meaning divisor value loaded at reset, truncated to DIV_W.
REQ-004 SHALL have parameter RESET_EN, default 1, meaning enable bit value loaded at reset.
REQ-005 clk  input  1  clock; all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 iocs  input  1  chip select; a register access happens only when high.
REQ-008 iorw  input  1  1 = read, 0 = write.
REQ-009 ioaddr  input  2  register select: 00 status, 01 control, 10 divisor low, 11 divisor high.
REQ-010 data_in  input  8  write data.
REQ-011 data_out  output  8  read data, combinational.
REQ-012 os_tick  output  1  oversample tick, one-clk pulse.
REQ-013 bit_tick  output  1  bit-rate tick, one-clk pulse coincident with every OSR-th os_tick.
REQ-014 running  output  1  high when enable=1 and active divisor != 0.

Function
REQ-015 Write 10 SHALL load staging_lo only; the active divisor and counters are unchanged.
REQ-016 Write 11 SHALL atomically commit active divisor = {data_in, staging_lo} (truncated to DIV_W), reload div counter to new divisor-1, clear oversample counter, with no tick in the commit cycle.
REQ-017 Write 01 SHALL set enable = data_in[0]; data_in[1]=1 SHALL restart (reload div counter to divisor-1, clear oversample counter, suppress tick that cycle); bit1 is self-clearing and reads back 0.
REQ-018 Writes to 00 SHALL be ignored.
REQ-019 Read (iocs=1, iorw=1) SHALL drive data_out: 00 -> {6'b0, running, enable}; 01 -> {7'b0, enable}; 10 -> active divisor[7:0]; 11 -> active divisor[15:8] (zero-extended); otherwise data_out = 0.
REQ-020 Reads of 10/11 SHALL return the active divisor, never staging_lo.
REQ-021 When running, div counter SHALL decrement each clk; at 0 it SHALL assert os_tick that cycle and reload divisor-1; period = divisor clks exactly.
REQ-022 Divisor 1 SHALL produce os_tick every clk; divisor 0 SHALL hold counters and produce no ticks (running=0).
REQ-023 Oversample counter SHALL increment on each os_tick, wrap from OSR-1 to 0, and bit_tick SHALL be asserted on the os_tick where it equals OSR-1.
REQ-024 enable 1->0 SHALL freeze both counters and force ticks low from the next cycle; 0->1 SHALL resume from frozen values.
REQ-025 A restart and a divisor commit in the same cycle cannot occur (single port); a write in a tick cycle SHALL take effect after that tick is emitted (the tick in that cycle is not retracted unless REQ-016/017 suppression applies, which takes priority).
REQ-026 os_tick and bit_tick SHALL be registered outputs, glitch-free, never high for two consecutive clks unless divisor = 1 (os_tick) or divisor = 1 and OSR legal minimum reached (bit_tick every OSR clks).

Reset
REQ-027 rst SHALL asynchronously set: active divisor = RESET_DIV, staging_lo = 0, enable = RESET_EN, div counter = RESET_DIV-1 (0 if RESET_DIV = 0), oversample counter = 0, os_tick = 0, bit_tick = 0.
REQ-028 rst asserted mid-count SHALL abort immediately; first os_tick after release occurs RESET_DIV clks after first active edge.

Verification
REQ-029 Reset defaults: release rst -> read 00 = 8'h03, 10 = 8'h45, 11 = 8'h01; os_tick every 325 clks, bit_tick every 5200 clks.
REQ-030 Atomic update: write 10 <= 8'h04 -> ticks unchanged, read 10 still 8'h45; write 11 <= 8'h00 -> os_tick period 4 clks, bit_tick period 64 clks, first os_tick 4 clks after commit.
REQ-031 Boundary divisors: divisor 1 -> os_tick constant high, bit_tick every 16 clks; divisor 0 -> no ticks, read 00 = 8'h01.
REQ-032 Enable/restart: divisor 10, disable for 37 clks mid-count -> no ticks, phase resumes; write 01 <= 8'h03 -> next os_tick exactly 10 clks later, bit_tick after 160 clks.
REQ-033 Async reset mid-operation: assert rst between edges with divisor 4 active -> ticks drop immediately, divisor reads 325 after release.
REQ-034 Parameter sweep: DIV_W=8, OSR=8 -> write 11 <= 8'hFF ignored in high byte (reads 8'h00), bit_tick = 8 os_ticks.
